// File: rtl/cap_cmd_pack_pkg.sv
// Shared definitions for the capture-card command link: framing constants,
// type codes and the transmitter state encoding (also used by the command parser).
package cap_cmd_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int unsigned MAX_PAYLOAD_BYTES = 3;

    localparam logic [7:0] CMD_CHANNEL = 8'd1;
    localparam logic [7:0] CMD_SPEED   = 8'd2;
    localparam logic [7:0] CMD_ENABLE  = 8'd3;
    localparam logic [7:0] CMD_TRIG    = 8'd4;
    localparam logic [7:0] CMD_SEEK    = 8'd5;

    localparam int unsigned OFS_TYPE = 1;
    localparam int unsigned OFS_PLEN = 2;
    localparam int unsigned OFS_PAY  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_TYPE,
        ST_PLEN,
        ST_PAY
    } cmd_state_t;

endpackage

// File: rtl/cap_cmd_pack_if.sv
// Request and byte-stream signals between status sources, the frame packer
// and the host-link transmitter.
interface cap_cmd_pack_if #(
    parameter int unsigned MAX_PAYLOAD = 3
);
    logic                     req_valid;
    logic                     req_ready;
    logic [7:0]               req_type;
    logic [7:0]               req_len;
    logic [8*MAX_PAYLOAD-1:0] req_data;
    logic [7:0]               cmd_len;
    logic [7:0]               cmd_data;
    logic                     cmd_last;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     err_len;

    // master: the packer itself; slave: request source plus byte sink
    modport master (
        input  req_valid, req_type, req_len, req_data, cmd_ready,
        output req_ready, cmd_len, cmd_data, cmd_last, cmd_valid, err_len
    );

    modport slave (
        output req_valid, req_type, req_len, req_data, cmd_ready,
        input  req_ready, cmd_len, cmd_data, cmd_last, cmd_valid, err_len
    );
endinterface

// File: rtl/cap_cmd_pack.sv
// Frame transmitter: serialises one request as HEADER, TYPE, PLEN, payload
// (MSB first) onto a valid/ready byte stream.
module cap_cmd_pack
    import cap_cmd_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_BYTE,
    parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_BYTES
) (
    input  logic           i_clk,
    input  logic           i_rst,
    cap_cmd_pack_if.master bus
);

    cmd_state_t               state, state_d;
    logic [7:0]               pay_cnt, cnt_d;
    logic [7:0]               type_q, type_d;
    logic [7:0]               len_q, len_d;
    logic [8*MAX_PAYLOAD-1:0] data_q, data_d;
    logic [7:0]               byte_sel;
    logic [7:0]               byte_d;
    logic                     last_d;
    logic                     accept, legal, xfer;

    assign bus.req_ready = (state == ST_IDLE);

    always_comb begin
        accept  = bus.req_valid && (state == ST_IDLE);
        legal   = (bus.req_len != 8'd0) && (bus.req_len <= 8'(MAX_PAYLOAD));
        xfer    = bus.cmd_valid && bus.cmd_ready;
        state_d = state;
        cnt_d   = pay_cnt;
        type_d  = type_q;
        len_d   = len_q;
        data_d  = data_q;

        if (accept && legal) begin
            type_d = bus.req_type;
            len_d  = bus.req_len;
            data_d = bus.req_data;
        end

        unique case (state)
            ST_IDLE: if (accept && legal) begin
                state_d = ST_HEAD;
                cnt_d   = '0;
            end
            ST_HEAD: if (xfer) state_d = ST_TYPE;
            ST_TYPE: if (xfer) state_d = ST_PLEN;
            ST_PLEN: if (xfer) begin
                state_d = ST_PAY;
                cnt_d   = 8'd1;
            end
            ST_PAY: if (xfer) begin
                if (pay_cnt == len_q) state_d = ST_IDLE;
                else                  cnt_d   = pay_cnt + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so a stalled byte is simply
    // recomputed unchanged and the data/last/len stay stable.
    always_comb begin
        byte_sel = len_d - cnt_d;
        byte_d   = '0;
        last_d   = 1'b0;
        unique case (state_d)
            ST_HEAD: byte_d = HEADER;
            ST_TYPE: byte_d = type_d;
            ST_PLEN: byte_d = len_d;
            ST_PAY: begin
                for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                    if (byte_sel == 8'(i)) byte_d = data_d[i*8 +: 8];
                end
                last_d = (cnt_d == len_d);
            end
            default: byte_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            pay_cnt       <= '0;
            type_q        <= '0;
            len_q         <= '0;
            data_q        <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_last  <= 1'b0;
            bus.cmd_data  <= '0;
            bus.cmd_len   <= '0;
            bus.err_len   <= 1'b0;
        end else begin
            state         <= state_d;
            pay_cnt       <= cnt_d;
            type_q        <= type_d;
            len_q         <= len_d;
            data_q        <= data_d;
            bus.cmd_valid <= (state_d != ST_IDLE);
            bus.cmd_last  <= last_d;
            bus.cmd_data  <= byte_d;
            bus.err_len   <= accept && !legal;
            if (accept && legal) bus.cmd_len <= 8'(OFS_PAY) + bus.req_len;
        end
    end

endmodule

// File: tb/tb_cap_cmd_pack.sv
// Directed bench for cap_cmd_pack with a small frame decoder for the loopback case.
module tb_cap_cmd_pack;
    import cap_cmd_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    cap_cmd_pack_if #(.MAX_PAYLOAD(3)) bus ();

    cap_cmd_pack #(.HEADER(8'hA5), .MAX_PAYLOAD(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side decoder standing in for the command parser
    int         p_idx;
    logic [7:0] p_type, p_len, p_cnt, p_channel;
    always @(posedge clk) begin
        if (rst) begin
            p_idx     <= 0;
            p_cnt     <= '0;
            p_type    <= '0;
            p_len     <= '0;
            p_channel <= '0;
        end else if (bus.cmd_valid && bus.cmd_ready) begin
            case (p_idx)
                0: if (bus.cmd_data == 8'hA5) p_idx <= 1;
                1: begin p_type <= bus.cmd_data; p_idx <= 2; end
                2: begin p_len <= bus.cmd_data; p_cnt <= '0; p_idx <= 3; end
                default: begin
                    p_cnt <= p_cnt + 8'd1;
                    if (p_cnt + 8'd1 == p_len) begin
                        if (p_type == 8'd1) p_channel <= bus.cmd_data;
                        p_idx <= 0;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] l, input logic [23:0] d);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_len   = l;
        bus.req_data  = d;
        step();
        bus.req_valid = 1'b0;
        bus.req_data  = 24'hDEAD00;
    endtask

    // Expects n bytes (packed MSB-first in exp) with ready held high
    task automatic expect_frame(input string tag, input int n, input logic [47:0] exp);
        logic [47:0] e;
        e = exp;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(bus.cmd_valid), 32'd1);
            chk({tag, "_data"}, 32'(bus.cmd_data), 32'(e[(n-1-i)*8 +: 8]));
            chk({tag, "_last"}, 32'(bus.cmd_last), 32'(i == n - 1));
            chk({tag, "_len"}, 32'(bus.cmd_len), 32'(n));
            chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd0);
            step();
        end
    endtask

    initial begin
        int         idx;
        logic [7:0] exp2 [4];
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_type  = '0;
        bus.req_len   = '0;
        bus.req_data  = '0;
        bus.cmd_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_last",  32'(bus.cmd_last),  32'd0);
        chk("rst_data",  32'(bus.cmd_data),  32'd0);
        chk("rst_len",   32'(bus.cmd_len),   32'd0);
        chk("rst_err",   32'(bus.err_len),   32'd0);
        chk("rst_rdy",   32'(bus.req_ready), 32'd1);

        // Speed readback, ready high
        send(8'd2, 8'd3, 24'h0186A0);
        expect_frame("speed", 6, 48'hA5_02_03_01_86_A0);
        chk("speed_end_valid", 32'(bus.cmd_valid), 32'd0);
        chk("speed_end_rdy",   32'(bus.req_ready), 32'd1);
        chk("speed_len_hold",  32'(bus.cmd_len),   32'd6);

        // Channel frame with ready pattern 1,0,0,1,0,0,...
        send(8'd1, 8'd1, 24'h00000F);
        exp2 = '{8'hA5, 8'h01, 8'h01, 8'h0F};
        idx  = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            bus.cmd_ready = (c % 3 == 0);
            chk("stall_valid", 32'(bus.cmd_valid), 32'd1);
            chk("stall_data",  32'(bus.cmd_data),  32'(exp2[idx]));
            chk("stall_last",  32'(bus.cmd_last),  32'(idx == 3));
            chk("stall_len",   32'(bus.cmd_len),   32'd4);
            step();
            if (bus.cmd_ready) idx++;
        end
        chk("stall_count", 32'(idx), 32'd4);
        chk("stall_end_valid", 32'(bus.cmd_valid), 32'd0);
        bus.cmd_ready = 1'b1;

        // Illegal lengths 0 and 4
        for (int k = 0; k < 2; k++) begin
            chk("ill_rdy_pre", 32'(bus.req_ready), 32'd1);
            send(8'd1, (k == 0) ? 8'd0 : 8'd4, 24'h123456);
            chk("ill_err",   32'(bus.err_len),   32'd1);
            chk("ill_valid", 32'(bus.cmd_valid), 32'd0);
            chk("ill_rdy",   32'(bus.req_ready), 32'd1);
            step();
            chk("ill_err_drop", 32'(bus.err_len),   32'd0);
            chk("ill_valid2",   32'(bus.cmd_valid), 32'd0);
        end

        // Back-to-back: trig then seek with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_type  = 8'd4;
        bus.req_len   = 8'd1;
        bus.req_data  = 24'h000001;
        step();
        bus.req_type  = 8'd5;
        expect_frame("trig", 4, 48'h0000_A5_04_01_01);
        chk("b2b_gap_valid", 32'(bus.cmd_valid), 32'd0);
        chk("b2b_gap_rdy",   32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        expect_frame("seek", 4, 48'h0000_A5_05_01_01);
        chk("seek_end_valid", 32'(bus.cmd_valid), 32'd0);

        // Reset during the PLEN byte of a speed frame
        send(8'd2, 8'd3, 24'h0186A0);
        step();
        step();
        chk("mid_plen", 32'(bus.cmd_data), 32'h03);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_valid", 32'(bus.cmd_valid), 32'd0);
        chk("mid_last",  32'(bus.cmd_last),  32'd0);
        chk("mid_rdy",   32'(bus.req_ready), 32'd1);
        send(8'd3, 8'd1, 24'h000001);
        expect_frame("enable", 4, 48'h0000_A5_03_01_01);

        // Loopback into the decoder
        send(8'd1, 8'd1, 24'h000005);
        expect_frame("loop", 4, 48'h0000_A5_01_01_05);
        step();
        chk("loop_channel", 32'(p_channel), 32'h05);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
